// File: rtl/serial_comp_fsm.sv
// Bit-serial MSB-first unsigned magnitude comparator with registered results.
// Define SERIAL_COMP_EARLY_EXIT_EN to finish on the first differing bit instead of after WIDTH bits.
module serial_comp_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeb,
    output logic             agb,
    output logic             alb
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IdxW-1:0]  idx_q;
    logic             decided_q, gt_q;

    logic a_bit, b_bit, diff, decided_d, gt_d, last, finish;

    // Only the first differing bit may set the sticky decision; later bits are ignored.
    always_comb begin
        a_bit     = a_q[idx_q];
        b_bit     = b_q[idx_q];
        diff      = !decided_q && (a_bit != b_bit);
        decided_d = decided_q | diff;
        gt_d      = diff ? a_bit : gt_q;
        last      = (idx_q == '0);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        finish    = diff | last;
`else
        finish    = last;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aeb       <= 1'b0;
            agb       <= 1'b0;
            alb       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        idx_q     <= IdxW'(WIDTH - 1);
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        aeb       <= 1'b0;
                        agb       <= 1'b0;
                        alb       <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    decided_q <= decided_d;
                    gt_q      <= gt_d;
                    if (finish) begin
                        aeb     <= !decided_d;
                        agb     <= decided_d & gt_d;
                        alb     <= decided_d & !gt_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
